hazard_forward_ctrl: RTL and testbench

//  Control side of the EX-stage operand forwarding path: generates the 2-bit forward_select codes consumed by
//  the forwarding muxes (rs1 -> fwd_a, rs2 -> fwd_b) plus load-use stall control for the 5-stage pipeline.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/fwd_select_logic.sv | 24 ++
 rtl/hazard_forward_ctrl.sv | 96 +++++++++
 tb/tb_hazard_forward_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX-stage forwarding controller.
// Optional feature macro: HAZARD_WB_BYPASS_EN (adds ID-stage WB bypass flags).
package hazard_pkg;

  localparam int HZ_ADDR_W = 5;

  // Forwarding mux select encoding (2'b11 is never produced)
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Destination tag carried down the shadow scoreboard
  typedef struct packed {
    logic                 valid;
    logic [HZ_ADDR_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '{valid: 1'b0, rd: '0, regwrite: 1'b0, memread: 1'b0};

  // A stage produces a forwardable result only if it really writes a non-x0 register
  function automatic logic is_writer(input stage_tag_t t);
    return t.valid & t.regwrite & (t.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_select_logic.sv
// Priority compare for one EX operand: EX/MEM result beats MEM/WB result.
module fwd_select_logic
  import hazard_pkg::*;
(
  input  logic [HZ_ADDR_W-1:0] i_src,
  input  logic                 i_use,
  input  logic                 i_valid,
  input  stage_tag_t           i_exmem,
  input  stage_tag_t           i_memwb,
  output logic [1:0]           o_sel
);

  // Youngest producer wins; a load in EX/MEM has no data yet, so it never forwards from there
  always_comb begin
    o_sel = FWD_REG;
    if (i_valid && i_use) begin
      if (is_writer(i_exmem) && !i_exmem.memread && (i_exmem.rd == i_src))
        o_sel = FWD_EXMEM;
      else if (is_writer(i_memwb) && (i_memwb.rd == i_src))
        o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding select and load-use stall control with a private shadow scoreboard
// of destination tags (ID/EX, EX/MEM, MEM/WB).
// Optional: HAZARD_WB_BYPASS_EN adds id_byp_a/id_byp_b for bypassing the regfile read in ID.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall
`ifdef HAZARD_WB_BYPASS_EN
  ,
  output logic                  id_byp_a,
  output logic                  id_byp_b
`endif
);

  stage_tag_t            r_idex;
  stage_tag_t            r_exmem;
  stage_tag_t            r_memwb;
  logic [REG_ADDR_W-1:0] r_idex_rs1;
  logic [REG_ADDR_W-1:0] r_idex_rs2;
  logic                  r_idex_use1;
  logic                  r_idex_use2;

  logic w_idex_load;
  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_idex_load = is_writer(r_idex) & r_idex.memread;
  assign w_hit_rs1   = id_use_rs1 & (id_rs1 == r_idex.rd);
  assign w_hit_rs2   = id_use_rs2 & (id_rs2 == r_idex.rd);

  // Load-use: the consumer waits one cycle so the load reaches MEM/WB; a flush kills the consumer anyway
  assign stall = id_valid & w_idex_load & ~flush & (w_hit_rs1 | w_hit_rs2);

  // Scoreboard advance: reset > hold > bubble (flush/stall) > normal
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idex  <= TAG_BUBBLE;
      r_exmem <= TAG_BUBBLE;
      r_memwb <= TAG_BUBBLE;
    end else if (!hold) begin
      r_exmem <= r_idex;
      r_memwb <= r_exmem;
      if (flush || stall) begin
        r_idex.valid <= 1'b0;
      end else begin
        r_idex      <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
        r_idex_rs1  <= id_rs1;
        r_idex_rs2  <= id_rs2;
        r_idex_use1 <= id_use_rs1;
        r_idex_use2 <= id_use_rs2;
      end
    end
  end

  fwd_select_logic u_fwd_a (
    .i_src   (r_idex_rs1),
    .i_use   (r_idex_use1),
    .i_valid (r_idex.valid),
    .i_exmem (r_exmem),
    .i_memwb (r_memwb),
    .o_sel   (fwd_a)
  );

  fwd_select_logic u_fwd_b (
    .i_src   (r_idex_rs2),
    .i_use   (r_idex_use2),
    .i_valid (r_idex.valid),
    .i_exmem (r_exmem),
    .i_memwb (r_memwb),
    .o_sel   (fwd_b)
  );

`ifdef HAZARD_WB_BYPASS_EN
  logic w_mw_writer;
  assign w_mw_writer = is_writer(r_memwb);
  assign id_byp_a    = w_mw_writer & (r_memwb.rd == id_rs1) & id_use_rs1 & id_valid;
  assign id_byp_b    = w_mw_writer & (r_memwb.rd == id_rs2) & id_use_rs2 & id_valid;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scoreboard bench: the driver pushes per-cycle expectations, the monitor
// pops and compares on the falling edge.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;
  logic       flush = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_use_rs1 = 1'b0;
  logic       id_use_rs2 = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_regwrite = 1'b0;
  logic       id_memread = 1'b0;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;
`ifdef HAZARD_WB_BYPASS_EN
  logic       id_byp_a;
  logic       id_byp_b;
`endif

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall)
`ifdef HAZARD_WB_BYPASS_EN
    ,
    .id_byp_a    (id_byp_a),
    .id_byp_b    (id_byp_b)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } id_t;

  typedef struct {
    string      nm;
    bit         cf;
    logic [1:0] a;
    logic [1:0] b;
    bit         cs;
    logic       s;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic id_t R(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return '{1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0};
  endfunction
  function automatic id_t I(input logic [4:0] rd, input logic [4:0] rs1);
    return '{1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b0};
  endfunction
  function automatic id_t LW(input logic [4:0] rd, input logic [4:0] rs1);
    return '{1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1};
  endfunction
  function automatic id_t NOP();
    return '0;
  endfunction

  // One pipeline cycle: drive ID/control inputs, queue what the outputs must show this cycle
  task automatic cyc(input id_t id, input bit fl, input bit hd, input bit rs, input string nm,
                     input bit cf, input logic [1:0] ea, input logic [1:0] eb,
                     input bit cs, input logic es);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = id.v;   id_rs1 = id.rs1; id_rs2 = id.rs2;
    id_use_rs1 = id.u1; id_use_rs2 = id.u2;
    id_rd = id.rd;     id_regwrite = id.rw; id_memread = id.mr;
    flush = fl; hold = hd; reset = rs;
    e.nm = nm; e.cf = cf; e.a = ea; e.b = eb; e.cs = cs; e.s = es;
    exp_q.push_back(e);
  endtask

  // Plain cycle with fwd/stall both checked
  task automatic chk(input id_t id, input string nm, input logic [1:0] ea, input logic [1:0] eb,
                     input logic es);
    cyc(id, 1'b0, 1'b0, 1'b0, nm, 1'b1, ea, eb, 1'b1, es);
  endtask

  // Cycle with no expectation
  task automatic go(input id_t id);
    cyc(id, 1'b0, 1'b0, 1'b0, "none", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) chk(NOP(), "drain", 2'b00, 2'b00, 1'b0);
  endtask

  // Monitor: compares the head expectation against the DUT away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.cf) begin
          total++;
          if (fwd_a !== e.a) begin
            bad++;
            $display("FAIL %s fwd_a: got %b want %b", e.nm, fwd_a, e.a);
          end
          total++;
          if (fwd_b !== e.b) begin
            bad++;
            $display("FAIL %s fwd_b: got %b want %b", e.nm, fwd_b, e.b);
          end
        end
        if (e.cs) begin
          total++;
          if (stall !== e.s) begin
            bad++;
            $display("FAIL %s stall: got %b want %b", e.nm, stall, e.s);
          end
        end
      end
    end
  end

  initial begin
    // Reset, then the first cycle out of reset must not forward or stall
    cyc(NOP(), 1'b0, 1'b0, 1'b1, "rst", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc(NOP(), 1'b0, 1'b0, 1'b1, "rst", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    chk(NOP(), "reset_state", 2'b00, 2'b00, 1'b0);
    drain();

    // add x5,x1,x2 ; add x6,x5,x3 -> EX/MEM forward on rs1
    go(R(5, 1, 2));
    chk(R(6, 5, 3), "t1_nostall", 2'b00, 2'b00, 1'b0);
    chk(NOP(), "t1_exmem", 2'b10, 2'b00, 1'b0);
    drain();

    // add x5 ; nop ; sub x7,x3,x5 -> MEM/WB forward on rs2
    go(R(5, 1, 2));
    go(NOP());
    go(R(7, 3, 5));
    chk(NOP(), "t2_memwb", 2'b00, 2'b01, 1'b0);
    drain();

    // add x5 ; add x5 ; or x8,x5,x5 -> youngest (EX/MEM) wins
    go(R(5, 1, 2));
    go(R(5, 1, 2));
    go(R(8, 5, 5));
    chk(NOP(), "t3_prio", 2'b10, 2'b10, 1'b0);
    drain();

    // lw x6 ; add x7,x6,x6 -> one bubble, then MEM/WB forward
    go(LW(6, 1));
    chk(R(7, 6, 6), "t4_stall", 2'b00, 2'b00, 1'b1);
    chk(R(7, 6, 6), "t4_release", 2'b00, 2'b00, 1'b0);
    chk(NOP(), "t4_fwd", 2'b01, 2'b01, 1'b0);
    drain();

    // writes to x0 never forward and a load to x0 never stalls
    go(I(0, 1));
    go(R(9, 0, 0));
    chk(NOP(), "t5_x0_fwd", 2'b00, 2'b00, 1'b0);
    go(LW(0, 1));
    chk(R(9, 0, 0), "t5_x0_stall", 2'b00, 2'b00, 1'b0);
    drain();

    // flush masks a pending load-use stall and bubbles ID/EX
    go(R(5, 1, 2));
    go(LW(6, 1));
    cyc(R(7, 6, 5), 1'b1, 1'b0, 1'b0, "t6_flush_stall", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    chk(NOP(), "t6_flush_bubble", 2'b00, 2'b00, 1'b0);
    drain();

    // hold for 3 cycles freezes the scoreboard
    go(R(5, 1, 2));
    go(R(6, 5, 3));
    cyc(NOP(), 1'b0, 1'b1, 1'b0, "t6_hold0", 1'b1, 2'b10, 2'b00, 1'b1, 1'b0);
    cyc(NOP(), 1'b0, 1'b1, 1'b0, "t6_hold1", 1'b1, 2'b10, 2'b00, 1'b1, 1'b0);
    cyc(NOP(), 1'b0, 1'b1, 1'b0, "t6_hold2", 1'b1, 2'b10, 2'b00, 1'b1, 1'b0);
    chk(NOP(), "t6_hold_rel", 2'b10, 2'b00, 1'b0);
    chk(NOP(), "t6_hold_adv", 2'b00, 2'b00, 1'b0);
    drain();

    // reset mid-stream discards the in-flight load
    go(LW(6, 1));
    cyc(R(7, 6, 6), 1'b0, 1'b0, 1'b1, "none", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    chk(R(7, 6, 6), "t6_reset_mid", 2'b00, 2'b00, 1'b0);
    chk(NOP(), "t6_reset_after", 2'b00, 2'b00, 1'b0);

    // let the monitor consume what is left, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
